// File: rtl/sequence_recognizer_controller.sv
// sequence_recognizer_controller: run-controlled Mealy recognizer for a programmable
// 3-symbol pattern, counting overlapping matches up to a target or until a no-match timeout.
module sequence_recognizer_controller #(
    parameter int NMATCH_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                Ck,
    input  logic                reset_,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_pat,
    input  logic                start,
    input  logic [NMATCH_W-1:0] target,
    input  logic [1:0]          X,
    output logic                Z,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [NMATCH_W-1:0] count
);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {R0, R1, R2} phase_t;

    state_t              state, state_n;
    phase_t              phase, phase_n, phase_adv;
    logic [5:0]          pat, pat_n;
    logic [NMATCH_W-1:0] count_n, tgt, tgt_n;
    logic [IW-1:0]       idle, idle_n;
    logic                done_n, timeout_n;

    always_ff @(posedge Ck or negedge reset_) begin
        if (!reset_) begin
            state   <= IDLE;
            phase   <= R0;
            pat     <= 6'b11_01_10;
            count   <= '0;
            tgt     <= '0;
            idle    <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            pat     <= pat_n;
            count   <= count_n;
            tgt     <= tgt_n;
            idle    <= idle_n;
            done    <= done_n;
            timeout <= timeout_n;
        end
    end

    assign busy = (state == RUN);
    assign Z    = (state == RUN) && (phase == R2) && (X == pat[1:0]);

    // A completed match falls through to the same P0 check, which gives overlap for free
    assign phase_adv = (phase == R1 && X == pat[3:2]) ? R2 : (X == pat[5:4]) ? R1 : R0;

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        pat_n     = pat;
        count_n   = count;
        tgt_n     = tgt;
        idle_n    = idle;
        done_n    = 1'b0;
        timeout_n = 1'b0;
        if (state == IDLE) begin
            if (cfg_we) pat_n = cfg_pat;
            if (start) begin
                count_n = '0;
                idle_n  = '0;
                phase_n = R0;
                tgt_n   = target;
                done_n  = (target == '0);
                state_n = (target == '0) ? IDLE : RUN;
            end
        end else begin
            phase_n = phase_adv;
            if (Z) begin
                count_n = count + NMATCH_W'(1);
                idle_n  = '0;
                done_n  = (count + NMATCH_W'(1) == tgt);
                state_n = done_n ? IDLE : RUN;
            end else begin
                idle_n    = idle + IW'(1);
                timeout_n = (idle == IW'(TIMEOUT - 1));
                state_n   = timeout_n ? IDLE : RUN;
            end
        end
    end
endmodule

// File: tb/tb_sequence_recognizer_controller.sv
// tb_sequence_recognizer_controller: directed vectors with hand-computed expectations,
// one instance at TIMEOUT=16 and one at TIMEOUT=4 sharing the same stimulus.
module tb_sequence_recognizer_controller;
    logic       Ck, reset_, cfg_we, start;
    logic [5:0] cfg_pat;
    logic [3:0] target;
    logic [1:0] X;
    logic       Z, busy, done, timeout;
    logic [3:0] count;
    logic       z4, busy4, done4, to4;
    logic [3:0] count4;
    int         checks = 0;
    int         errors = 0;

    sequence_recognizer_controller #(.NMATCH_W(4), .TIMEOUT(16)) dut (
        .Ck(Ck), .reset_(reset_), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .start(start),
        .target(target), .X(X), .Z(Z), .busy(busy), .done(done), .timeout(timeout),
        .count(count)
    );

    sequence_recognizer_controller #(.NMATCH_W(4), .TIMEOUT(4)) dut4 (
        .Ck(Ck), .reset_(reset_), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .start(start),
        .target(target), .X(X), .Z(z4), .busy(busy4), .done(done4), .timeout(to4),
        .count(count4)
    );

    initial Ck = 1'b0;
    always #5 Ck = ~Ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Ck);
        #1;
    endtask

    task automatic sym(input logic [1:0] x, input logic ez, input string tag);
        X = x;
        @(negedge Ck);
        check(tag, Z, ez);
        step();
    endtask

    task automatic sym4(input logic [1:0] x, input logic ez, input string tag);
        X = x;
        @(negedge Ck);
        check(tag, z4, ez);
        step();
    endtask

    task automatic run_default(input string p);
        start = 1; target = 2; X = 0;
        step();
        start = 0;
        check({p, "_busy_up"}, busy, 1);
        check({p, "_cnt0"}, count, 0);
        sym(2'b11, 0, {p, "_z1"});
        sym(2'b01, 0, {p, "_z2"});
        sym(2'b10, 1, {p, "_z3"});
        check({p, "_cnt1"}, count, 1);
        check({p, "_busy_mid"}, busy, 1);
        sym(2'b11, 0, {p, "_z4"});
        sym(2'b01, 0, {p, "_z5"});
        sym(2'b10, 1, {p, "_z6"});
        check({p, "_done"}, done, 1);
        check({p, "_busy_dn"}, busy, 0);
        check({p, "_cnt2"}, count, 2);
        check({p, "_to"}, timeout, 0);
        step();
        check({p, "_done_end"}, done, 0);
    endtask

    initial begin
        reset_ = 0; cfg_we = 0; cfg_pat = 0; start = 0; target = 0; X = 0;
        #3;
        check("rst_z", Z, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_to", timeout, 0);
        check("rst_cnt", count, 0);
        #9 reset_ = 1;
        step();

        run_default("def");

        // overlap with new pattern written on the same edge as start
        cfg_we = 1; cfg_pat = 6'b01_10_01; start = 1; target = 3;
        step();
        cfg_we = 0; start = 0;
        check("ov_busy", busy, 1);
        sym(2'b01, 0, "ov_z1");
        sym(2'b10, 0, "ov_z2");
        cfg_we = 1; cfg_pat = 6'b00_00_00; start = 1; target = 7;
        sym(2'b01, 1, "ov_z3");
        check("ov_cnt1", count, 1);
        sym(2'b10, 0, "ov_z4");
        cfg_we = 0; start = 0;
        check("ign_cnt", count, 1);
        sym(2'b01, 1, "ov_z5");
        check("ov_cnt2", count, 2);
        check("ov_busy2", busy, 1);
        sym(2'b10, 0, "ov_z6");
        sym(2'b01, 1, "ov_z7");
        check("ov_done", done, 1);
        check("ov_cnt3", count, 3);
        check("ov_busy_dn", busy, 0);

        // start in the done pulse cycle with target 0
        start = 1; target = 0;
        step();
        start = 0;
        check("t0_done", done, 1);
        check("t0_busy", busy, 0);
        check("t0_cnt", count, 0);
        step();
        check("t0_done_end", done, 0);
        check("t0_busy_end", busy, 0);

        // timeout with TIMEOUT=16
        start = 1; target = 5; X = 0;
        step();
        start = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("to_busy", busy, 1);
            check("to_nodone", done, 0);
        end
        step();
        check("to_pulse", timeout, 1);
        check("to_busy_dn", busy, 0);
        check("to_cnt", count, 0);
        check("to_done", done, 0);
        step();
        check("to_pulse_end", timeout, 0);

        // async reset mid-run while Z is high
        start = 1; target = 3; X = 0;
        step();
        start = 0;
        sym(2'b01, 0, "ar_z1");
        sym(2'b10, 0, "ar_z2");
        sym(2'b01, 1, "ar_z3");
        sym(2'b10, 0, "ar_z4");
        X = 2'b01;
        @(negedge Ck);
        check("ar_zpre", Z, 1);
        check("ar_cntpre", count, 1);
        #2 reset_ = 0;
        #1;
        check("ar_z", Z, 0);
        check("ar_busy", busy, 0);
        check("ar_cnt", count, 0);
        check("ar_done", done, 0);
        check("ar_to", timeout, 0);
        @(negedge Ck);
        reset_ = 1;
        step();
        run_default("post");

        // TIMEOUT=4: match on the 4th counted edge rescues the run
        start = 1; target = 2; X = 0;
        step();
        start = 0;
        check("rs_busy", busy4, 1);
        sym4(2'b00, 0, "rs_z1");
        sym4(2'b11, 0, "rs_z2");
        sym4(2'b01, 0, "rs_z3");
        sym4(2'b10, 1, "rs_z4");
        check("rs_noto", to4, 0);
        check("rs_busy2", busy4, 1);
        check("rs_cnt", count4, 1);
        sym4(2'b00, 0, "rs_z5");
        sym4(2'b00, 0, "rs_z6");
        sym4(2'b00, 0, "rs_z7");
        check("rs_busy3", busy4, 1);
        check("rs_noto2", to4, 0);
        sym4(2'b00, 0, "rs_z8");
        check("rs_to", to4, 1);
        check("rs_busy_dn", busy4, 0);
        check("rs_cnt_keep", count4, 1);
        check("rs_nodone", done4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sequence_recognizer_controller.md
# sequence_recognizer_controller

Programmable, run-controlled Mealy recognizer for 2-bit symbol streams. A 3-symbol pattern (default 11, 01, 10) is loaded through a config port. A run is armed with `start`, and the block counts overlapping pattern matches until a programmed target is reached or a no-match timeout expires. It sits between the symbol source and the downstream consumer of `Z`, and supplies run status (`busy`, `done`, `timeout`, `count`) to the sequencing logic above it.

## Interface
- `NMATCH_W`, default 4: width of `target` and `count`.
- `TIMEOUT`, default 16: consecutive non-match RUN cycles that abort a run; must be ≥ 1. The idle counter is `$clog2(TIMEOUT+1)` bits wide.
- `Ck`  in  1: single clock; all state changes on the rising edge.
- `reset_`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: pattern write strobe.
- `cfg_pat`  in  6: pattern symbols; P0 = [5:4], P1 = [3:2], P2 = [1:0].
- `start`  in  1: arm a run, level-sampled on the edge.
- `target`  in  NMATCH_W: matches required; sampled on the accepted `start`.
- `X`  in  2: input symbol, sampled on the edge.
- `Z`  out  1: Mealy match output, combinational.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when the target is reached.
- `timeout`  out  1: one-cycle pulse when a run is aborted.
- `count`  out  NMATCH_W: matches in the current or last run.

## Operation
- Controller states: IDLE and RUN. Recognizer sub-state: R0 (nothing matched), R1 (P0 seen), R2 (P0 P1 seen).
- Recognizer transitions, evaluated only in RUN:
  - From R0: X == P0 → R1; otherwise R0.
  - From R1: X == P1 → R2; else X == P0 → R1; else R0.
  - From R2: X == P2 is a match; next state is R1 if X == P0, else R0. For any other X: X == P0 → R1; else R0.
- Matches overlap, e.g. the final symbol may start the next pattern.
- `Z` = RUN & (sub-state == R2) & (X == P2). It is purely combinational from state and X, with no registered delay.
- Pattern register (6 bits):
  - Reset value 6'b11_01_10.
  - Written on an edge where `cfg_we` = 1 and state is IDLE.
  - `cfg_we` in RUN is ignored and the pattern is unchanged.
- Start:
  - Accepted on an edge with `start` = 1 in IDLE.
  - Clears `count` and the idle counter, sets the sub-state to R0, latches `target`.
  - If `target` == 0: stays in IDLE and `done` pulses in the next cycle.
  - Otherwise enters RUN.
  - `start` in RUN is ignored.
- `start` and `cfg_we` on the same IDLE edge: both are accepted, and the run uses the new pattern.
- Match counting:
  - On each RUN edge where `Z` = 1, `count` increments.
  - If `count` + 1 == latched target: go to IDLE, pulse `done` next cycle, freeze `count`.
- Timeout:
  - The idle counter increments on each RUN edge without a match and clears on a match.
  - A non-match edge with idle counter == TIMEOUT−1 goes to IDLE and pulses `timeout`. `count` keeps its partial value.
  - A match on the same edge wins: no timeout.
- `done` and `timeout` are never high together.
- `count` holds its value in IDLE until the next accepted start.
- Width rule: `count` never exceeds the target, so there is no wrap-around.

## Timing
- Reset asserted at any time, including mid-run, immediately forces:
  - State IDLE, sub-state R0.
  - `count` = 0, idle counter = 0, latched target = 0, pattern = 11_01_10.
  - `busy` = 0, `done` = 0, `timeout` = 0, `Z` = 0.
- Reset release: the first active edge is the first rising `Ck` with `reset_` = 1.
- `busy` is registered. It rises in the cycle after the accepted start, and falls in the cycle after the final-match or timeout edge, the same cycle `done` or `timeout` is high.
- Symbol sampling: the first X examined is the one present at the edge after the accepted start.
- Latency: the match is visible on `Z` during the cycle P2 is presented. `count` updates at that cycle's closing edge.
- Pulses: `done` and `timeout` are registered and high for exactly one cycle. `start` in the pulse cycle is accepted, because state is already IDLE.

## Test plan
- Reset default pattern: start with `target`=2, X = 11, 01, 10, 11, 01, 10.
  - `Z` is high in the 3rd and 6th cycles.
  - `count` goes 1 then 2, `done` pulses once, `busy` falls with it.
- Overlap: write `cfg_pat` = 01_10_01, start with `target`=3, X = 01, 10, 01, 10, 01, 10, 01.
  - Matches at symbols 3, 5 and 7 (overlapping).
  - `done` after the 7th symbol, `count` = 3.
- Timeout: start with `target`=5, TIMEOUT=16, hold X = 00.
  - `timeout` pulses in the cycle after the 16th non-match edge.
  - `count` = 0, `done` never asserts.
- Match rescues timeout: with TIMEOUT=4, complete a pattern whose P2 lands on the 4th non-match-counted edge.
  - No timeout, idle counter restarts, `count` = 1.
- Ignored controls: during RUN, assert `cfg_we` with a new pattern and assert `start`.
  - Pattern, latched target and `count` are unchanged.
  - `target`=0 start gives `done` the next cycle with `busy` staying 0.
- Async reset mid-run: drop `reset_` between edges while R2 has `Z` = 1.
  - All outputs go to 0 without a clock edge.
  - Pattern returns to 11_01_10, and the next start behaves as in the first test.
